// File: rtl/sdram_delay_pkg.sv
// Shared types and helpers for the SDRAM circular audio delay line.
// The sat16 helper is used only when SDRAM_DELAY_FEEDBACK_EN is defined.
package sdram_delay_pkg;

    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Clamp a 17-bit signed sum into the 16-bit signed sample range.
    function automatic logic signed [15:0] sat16(input logic signed [16:0] x);
        if (x > 17'sd32767)
            return 16'sh7fff;
        else if (x < -17'sd32768)
            return 16'sh8000;
        else
            return x[15:0];
    endfunction

endpackage

// File: rtl/sdram_delay_ptr.sv
// Buffer bookkeeping for the delay line: write pointer, fill level,
// clamped delay and the derived read pointer.
module sdram_delay_ptr #(
    parameter int DEPTH_LOG2 = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  advance,
    input  logic [DEPTH_LOG2-1:0] delay,
    output logic [DEPTH_LOG2-1:0] wr_ptr,
    output logic [DEPTH_LOG2-1:0] rd_ptr,
    output logic [DEPTH_LOG2-1:0] d,
    output logic [DEPTH_LOG2-1:0] fill_cnt,
    output logic                  mute
);

    localparam logic [DEPTH_LOG2-1:0] FILL_MAX = '1;
    localparam logic [DEPTH_LOG2-1:0] ONE      = DEPTH_LOG2'(1);

    // delay is DEPTH_LOG2 bits wide, so only the lower clamp bound can bite.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            fill_cnt <= '0;
            d        <= '0;
        end else begin
            if (load)
                d <= (delay == '0) ? ONE : delay;
            if (advance) begin
                wr_ptr <= wr_ptr + ONE;
                if (fill_cnt != FILL_MAX)
                    fill_cnt <= fill_cnt + ONE;
            end
        end
    end

    // Natural DEPTH_LOG2-bit wrap gives the modulo-DEPTH subtraction.
    assign rd_ptr = wr_ptr - d;
    // Words not yet written since reset must never reach the output.
    assign mute   = (d > fill_cnt);

endmodule

// File: rtl/sdram_delay_line.sv
// Avalon-MM master using SDRAM as a circular audio delay buffer: read the
// delayed sample, write the new one. Optional feedback: SDRAM_DELAY_FEEDBACK_EN.
module sdram_delay_line
    import sdram_delay_pkg::*;
#(
    parameter int                ADDR_W     = 26,
    parameter int                DATA_W     = DEFAULT_DATA_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                DEPTH_LOG2 = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     in_sample,
    input  logic                  in_valid,
    input  logic [DEPTH_LOG2-1:0] delay,
    output logic [DATA_W-1:0]     out_sample,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  overrun,
    output logic [ADDR_W-1:0]     master_address,
    output logic                  master_read,
    output logic                  master_write,
    output logic [DATA_W-1:0]     master_writedata,
    input  logic [DATA_W-1:0]     master_readdata,
    input  logic                  master_waitrequest,
    output logic [1:0]            state_dbg
);

    // Avalon handshake: a request (master_read or master_write) is held with
    // constant address/data until a cycle where master_waitrequest is low;
    // that cycle completes the transfer and, for reads, carries readdata.

    state_t state, state_next;

    logic signed [DATA_W-1:0] s_in;
    logic signed [DATA_W-1:0] rd_data;
    logic signed [DATA_W-1:0] out_q;
    logic signed [DATA_W-1:0] wdata;

    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, d, fill_cnt;
    logic                  mute;
    logic                  accept;
    logic                  advance;
    logic [ADDR_W-1:0]     rd_addr, wr_addr;

    assign accept  = in_valid && (state == IDLE);
    assign advance = (state == DONE);

    sdram_delay_ptr #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ptr (
        .clk      (clk),
        .rst      (reset),
        .load     (accept),
        .advance  (advance),
        .delay    (delay),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .d        (d),
        .fill_cnt (fill_cnt),
        .mute     (mute)
    );

    // Word index to byte address: samples are 16-bit, so step by 2.
    assign rd_addr = BASE_ADDR + ADDR_W'({rd_ptr, 1'b0});
    assign wr_addr = BASE_ADDR + ADDR_W'({wr_ptr, 1'b0});

`ifdef SDRAM_DELAY_FEEDBACK_EN
    logic signed [DATA_W-1:0] masked_rd;
    logic signed [DATA_W:0]   fb_sum;

    assign masked_rd = mute ? '0 : rd_data;
    assign fb_sum    = {s_in[DATA_W-1], s_in}
                     + {{2{masked_rd[DATA_W-1]}}, masked_rd[DATA_W-1:1]};
    assign wdata     = sat16(fb_sum);
`else
    assign wdata = s_in;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            s_in    <= '0;
            rd_data <= '0;
            out_q   <= '0;
        end else begin
            state <= state_next;
            if (accept)
                s_in <= in_sample;
            if (state == READ && !master_waitrequest)
                rd_data <= master_readdata;
            // Output updates as DONE is entered and holds until the next DONE.
            if (state == WRITE && !master_waitrequest)
                out_q <= mute ? '0 : rd_data;
        end
    end

    always_comb begin
        state_next       = state;
        master_read      = 1'b0;
        master_write     = 1'b0;
        master_address   = '0;
        master_writedata = '0;
        case (state)
            IDLE: begin
                if (in_valid)
                    state_next = READ;
            end
            READ: begin
                master_read    = 1'b1;
                master_address = rd_addr;
                if (!master_waitrequest)
                    state_next = WRITE;
            end
            WRITE: begin
                master_write     = 1'b1;
                master_address   = wr_addr;
                master_writedata = wdata;
                if (!master_waitrequest)
                    state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign out_sample = out_q;
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign overrun    = in_valid && (state != IDLE);
    assign state_dbg  = state;

endmodule
